// File: rtl/vend_pkg.sv
// Shared types and constants for the vend dispense path.
package vend_pkg;

  localparam logic [2:0]  COIN_1 = 3'b001;
  localparam logic [2:0]  COIN_2 = 3'b010;
  localparam logic [2:0]  COIN_5 = 3'b101;
  localparam int unsigned PRICE  = 7;
  localparam int unsigned CHG_W  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StMotor,
    StWaitItem,
    StEject,
    StFault
  } vend_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_dispense_sequencer_if.sv
// Vend request handshake from the coin FSM into the dispense sequencer.
interface vend_dispense_sequencer_if;
  import vend_pkg::*;

  logic             req_valid;
  logic [CHG_W-1:0] req_change;
  logic             req_ready;

  modport master (output req_valid, output req_change, input req_ready);
  modport slave (input req_valid, input req_change, output req_ready);

endinterface

// File: rtl/vend_req_fifo.sv
// Request queue holding the change owed per accepted vend.
module vend_req_fifo #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 2,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = AddrW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;
  assign count_d = count_q + CntW'(do_push) - CntW'(do_pop);

  // Storage needs no reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= din;
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CntW'(Depth));
      empty_q <= (count_d == '0);
    end
  end

  assign dout  = mem[rptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Runs motor, item confirmation and change ejection for each queued vend.
module vend_dispense_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned MOTOR_CYCLES = 8,
  parameter int unsigned WAIT_TIMEOUT = 64,
  parameter int unsigned EJECT_CYCLES = 4,
  parameter int unsigned QDEPTH       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  vend_dispense_sequencer_if.slave req,
  input  logic                     item_sensed,
  input  logic                     fault_clr,
  output logic                     motor_on,
  output logic                     eject2,
  output logic                     eject1,
  output logic                     busy,
  output logic                     fault,
  output logic                     overflow,
  output logic [1:0]               pending
);

  localparam int unsigned CntMax   = max_u(max_u(MOTOR_CYCLES, WAIT_TIMEOUT), EJECT_CYCLES + 1);
  localparam int unsigned CntW     = $clog2(CntMax) + 1;
  localparam int unsigned FifoCntW = $clog2(QDEPTH) + 1;
  localparam logic [CntW-1:0] MotorLast = CntW'(MOTOR_CYCLES - 1);
  localparam logic [CntW-1:0] WaitLast  = CntW'(WAIT_TIMEOUT - 1);
  localparam logic [CntW-1:0] EjectGap  = CntW'(EJECT_CYCLES);

  vend_state_e         state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CHG_W-1:0]    chg_q, chg_d;   // change still owed for the vend in service
  logic [CHG_W-1:0]    chg_left;
  logic                two_owed;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CHG_W-1:0]    fifo_dout;
  logic [FifoCntW-1:0] fifo_count;
  logic motor_q, eject2_q, eject1_q, busy_q, fault_q, overflow_q;

  assign fifo_push = req.req_valid & req.req_ready;

  vend_req_fifo #(
    .Width (CHG_W),
    .Depth (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (req.req_change),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // 2-rupee coins drain first; the odd rupee goes last.
  assign two_owed = (chg_q[CHG_W-1:1] != '0);
  assign chg_left = chg_q - (two_owed ? CHG_W'(2) : CHG_W'(1));

  // Next-state, counter and change bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    chg_d    = chg_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          chg_d    = fifo_dout;
          cnt_d    = '0;
          state_d  = StMotor;
        end
      end
      StMotor: begin
        if (cnt_q == MotorLast) begin
          cnt_d   = '0;
          state_d = StWaitItem;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitItem: begin
        // A sensor hit on the timeout cycle still wins over the fault.
        if (item_sensed) begin
          cnt_d   = '0;
          state_d = (chg_q == '0) ? StIdle : StEject;
        end else if (cnt_q == WaitLast) begin
          chg_d   = '0;
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEject: begin
        // Strobe occupies counts 0..EJECT_CYCLES-1, the gap is the last count.
        if (cnt_q == EjectGap) begin
          cnt_d = '0;
          chg_d = chg_left;
          if (chg_left == '0) state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFault: begin
        if (fault_clr) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      chg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
    end
  end

  // Registered drives, decoded from the current state so they never overlap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      motor_q    <= 1'b0;
      eject2_q   <= 1'b0;
      eject1_q   <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      motor_q    <= (state_q == StMotor);
      eject2_q   <= (state_q == StEject) && (cnt_q < EjectGap) && two_owed;
      eject1_q   <= (state_q == StEject) && (cnt_q < EjectGap) && !two_owed;
      busy_q     <= (state_q != StIdle) || !fifo_empty;
      fault_q    <= (state_q == StFault);
      overflow_q <= (overflow_q & ~fault_clr) | (req.req_valid & ~req.req_ready);
    end
  end

  assign req.req_ready = ~fifo_full;
  assign motor_on      = motor_q;
  assign eject2        = eject2_q;
  assign eject1        = eject1_q;
  assign busy          = busy_q;
  assign fault         = fault_q;
  assign overflow      = overflow_q;
  assign pending       = (fifo_count > FifoCntW'(3)) ? 2'd3 : 2'(fifo_count);

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Self-checking bench for vend_dispense_sequencer.
module tb_vend_dispense_sequencer;

  localparam int M  = 8;
  localparam int E  = 4;
  localparam int NV = 12;

  logic       clk, reset, item_sensed, fault_clr;
  logic       motor_on, eject2, eject1, busy, fault, overflow;
  logic [1:0] pending;

  int checks = 0;
  int errors = 0;
  int sbq[$];

  typedef struct {
    int chg; int dly; int n2; int n1; int hi2; int hi1; int busy_off;
  } vec_t;
  vec_t vecs [8];

  vend_dispense_sequencer_if bus ();

  vend_dispense_sequencer #(
    .MOTOR_CYCLES (8),
    .WAIT_TIMEOUT (64),
    .EJECT_CYCLES (4),
    .QDEPTH       (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (bus),
    .item_sensed (item_sensed),
    .fault_clr   (fault_clr),
    .motor_on    (motor_on),
    .eject2      (eject2),
    .eject1      (eject1),
    .busy        (busy),
    .fault       (fault),
    .overflow    (overflow),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Eject window in cycles: every coin is EJECT strobe cycles plus one gap, plus one to idle.
  function automatic int win(input int c);
    return (E + 1) * (c / 2 + c % 2) + 1;
  endfunction

  task automatic send(input int c);
    bus.req_valid  = 1'b1;
    bus.req_change = 3'(c);
    step();
    bus.req_valid  = 1'b0;
  endtask

  // Waits for the motor, measures it, answers with item_sensed at WAIT count d (d>=1),
  // then watches the eject outputs for 'window' cycles.
  task automatic serve(input int d, input int window, output int lat, output int m_hi,
                       output int n2, output int n1, output int h2, output int h1,
                       output int boff, output int bad);
    logic p2, p1, seen1;
    lat = 0; m_hi = 0; n2 = 0; n1 = 0; h2 = 0; h1 = 0; boff = -1; bad = 0;
    while (!motor_on && lat < 3000) begin
      step();
      lat++;
    end
    if (!motor_on) begin
      checks++;
      errors++;
      $display("FAIL motor_rise: motor_on=%0b after %0d cycles, required 1", motor_on, lat);
      return;
    end
    while (motor_on && m_hi < 300) begin
      m_hi++;
      step();
    end
    repeat (d - 1) step();
    item_sensed = 1'b1;
    step();
    item_sensed = 1'b0;
    p2 = 1'b0; p1 = 1'b0; seen1 = 1'b0;
    for (int i = 1; i <= window; i++) begin
      step();
      if (eject2 && !p2) n2++;
      if (eject1 && !p1) n1++;
      if (eject2) h2++;
      if (eject1) h1++;
      if ((eject1 && eject2) || (motor_on && (eject1 || eject2)) || (eject2 && seen1)) bad++;
      if (eject1) seen1 = 1'b1;
      if (!busy && boff < 0) boff = i;
      p2 = eject2;
      p1 = eject1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  int lat, mh, n2, n1, h2, h1, boff, bad, cnt;

  initial begin
    // change, item delay, eject2 strobes, eject1 strobes, eject2 highs, eject1 highs, busy off
    vecs[0] = '{3, 2, 1, 1, 4, 4, 11};
    vecs[1] = '{0, 2, 0, 0, 0, 0, 1};
    vecs[2] = '{7, 5, 3, 1, 12, 4, 21};
    vecs[3] = '{4, 63, 2, 0, 8, 0, 11};
    vecs[4] = '{1, 1, 0, 1, 0, 4, 6};
    vecs[5] = '{6, 10, 3, 0, 12, 0, 16};
    vecs[6] = '{5, 30, 2, 1, 8, 4, 16};
    vecs[7] = '{2, 1, 1, 0, 4, 0, 6};

    reset = 1'b1; item_sensed = 1'b0; fault_clr = 1'b0;
    bus.req_valid = 1'b0; bus.req_change = 3'd0;
    #12;
    check("rst_motor", motor_on, 0);
    check("rst_eject2", eject2, 0);
    check("rst_eject1", eject1, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_overflow", overflow, 0);
    check("rst_pending", pending, 0);
    check("rst_ready", bus.req_ready, 1);
    reset = 1'b0;
    step();

    for (int v = 0; v < 8; v++) begin
      send(vecs[v].chg);
      serve(vecs[v].dly, win(vecs[v].chg), lat, mh, n2, n1, h2, h1, boff, bad);
      check($sformatf("vec%0d_motor_latency", v), lat, 2);
      check($sformatf("vec%0d_motor_cycles", v), mh, M);
      check($sformatf("vec%0d_eject2_strobes", v), n2, vecs[v].n2);
      check($sformatf("vec%0d_eject1_strobes", v), n1, vecs[v].n1);
      check($sformatf("vec%0d_eject2_high", v), h2, vecs[v].hi2);
      check($sformatf("vec%0d_eject1_high", v), h1, vecs[v].hi1);
      check($sformatf("vec%0d_busy_off", v), boff, vecs[v].busy_off);
      check($sformatf("vec%0d_overlap", v), bad, 0);
    end

    // Jam: no item ever arrives.
    send(5);
    repeat (M + 65) step();
    check("jam_fault_early", fault, 0);
    step();
    check("jam_fault", fault, 1);
    check("jam_motor", motor_on, 0);
    check("jam_busy", busy, 1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    step();
    check("jam_fault_cleared", fault, 0);
    cnt = 0;
    repeat (12) begin
      step();
      if (eject1 || eject2 || motor_on) cnt++;
    end
    check("jam_no_eject", cnt, 0);
    check("jam_busy_off", busy, 0);

    // Back-to-back requests while the first vend is in MOTOR.
    do_reset();
    send(1);
    step();
    step();
    check("q_motor_on", motor_on, 1);
    bus.req_valid = 1'b1;
    bus.req_change = 3'd2;
    step();
    bus.req_change = 3'd7;
    step();
    check("q_pending", pending, 2);
    check("q_ready_full", bus.req_ready, 0);
    bus.req_change = 3'd4;
    step();
    bus.req_valid = 1'b0;
    check("q_overflow", overflow, 1);
    check("q_pending_after_drop", pending, 2);
    serve(3, win(1), lat, mh, n2, n1, h2, h1, boff, bad);
    check("q_v1_eject2", n2, 0);
    check("q_v1_eject1", n1, 1);
    check("q_v1_overlap", bad, 0);
    serve(4, win(2), lat, mh, n2, n1, h2, h1, boff, bad);
    check("q_v2_motor", mh, M);
    check("q_v2_eject2", n2, 1);
    check("q_v2_eject1", n1, 0);
    serve(2, win(7), lat, mh, n2, n1, h2, h1, boff, bad);
    check("q_v3_motor", mh, M);
    check("q_v3_eject2", n2, 3);
    check("q_v3_eject1", n1, 1);
    check("q_v3_eject2_high", h2, 12);
    check("q_v3_overlap", bad, 0);
    check("q_v3_busy_off", boff, 21);
    check("q_pending_empty", pending, 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("q_overflow_cleared", overflow, 0);

    // Reset in the middle of the second 2-rupee strobe.
    send(4);
    repeat (M + 1) step();
    item_sensed = 1'b1;
    step();
    item_sensed = 1'b0;
    repeat (7) step();
    check("rm_eject2_before", eject2, 1);
    reset = 1'b1;
    #1;
    check("rm_eject2", eject2, 0);
    check("rm_pending", pending, 0);
    check("rm_ready", bus.req_ready, 1);
    check("rm_busy", busy, 0);
    step();
    reset = 1'b0;
    step();
    send(0);
    serve(1, win(0), lat, mh, n2, n1, h2, h1, boff, bad);
    check("rm_fresh_latency", lat, 2);
    check("rm_fresh_motor", mh, M);
    check("rm_fresh_busy_off", boff, 1);
    check("rm_fresh_eject", n2 + n1, 0);

    // Random traffic scored against per-request expectations.
    fork
      begin : driver
        int c, g;
        for (int k = 0; k < NV; k++) begin
          repeat ($urandom_range(0, 25)) step();
          g = 0;
          while (sbq.size() >= 2 && g < 3000) begin
            step();
            g++;
          end
          c = int'($urandom_range(0, 7));
          check($sformatf("rnd%0d_ready", k), bus.req_ready, 1);
          sbq.push_back(c);
          send(c);
        end
      end
      begin : responder
        int c, g, rl, rm, r2, r1, rh2, rh1, rb, rbad;
        for (int k = 0; k < NV; k++) begin
          g = 0;
          while (!motor_on && g < 3000) begin
            step();
            g++;
          end
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rnd%0d_vend: got motor_on=%0b with no request queued, required 1",
                     k, motor_on);
          end else begin
            c = sbq.pop_front();
            serve(int'($urandom_range(1, 40)), win(c), rl, rm, r2, r1, rh2, rh1, rb, rbad);
            check($sformatf("rnd%0d_motor", k), rm, M);
            check($sformatf("rnd%0d_eject2", k), r2, c / 2);
            check($sformatf("rnd%0d_eject1", k), r1, c % 2);
            check($sformatf("rnd%0d_eject2_high", k), rh2, E * (c / 2));
            check($sformatf("rnd%0d_eject1_high", k), rh1, E * (c % 2));
            check($sformatf("rnd%0d_overlap", k), rbad, 0);
          end
        end
      end
    join
    step();
    check("rnd_busy_end", busy, 0);
    check("rnd_overflow_end", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
